mux_share_arb: RTL and testbench
================================

Name: mux_share_arb

Overview:
- Round-robin arbiter that shares one 2:1 datapath mux between two requesters, A and B.
- Drives the mux select. Select 0 passes A and select 1 passes B, the same convention as the existing 2:1 mux (c==0 ? a : b).
- Registers the selected word into a single-entry output stage with a valid/ready handshake.
- Sits between two producer blocks and one shared consumer. It also keeps per-requester grant counters for debug.

Parameters:
- WIDTH, 2, data width of each requester and of the output.
- CNT_W, 8, width of each saturating grant counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_a  input  1  requester A has a word; held high with data_a stable until ack_a
- data_a  input  WIDTH  requester A word
- ack_a  output  1  A's word is captured at this clock edge (combinational, one cycle per word)
- req_b  input  1  requester B has a word
- data_b  input  WIDTH  requester B word
- ack_b  output  1  B's word is captured at this clock edge
- sel  output  1  current mux select: 0 = A, 1 = B
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  output word
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready
- cnt_a  output  CNT_W  number of grants to A, saturating
- cnt_b  output  CNT_W  number of grants to B, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values:
  - out_valid=0, out_data=0, cnt_a=0, cnt_b=0.
  - last_served=B, so A wins the first contention.
  - ack_a and ack_b evaluate to 0 while rst=1.
- Slot free: slot_free = !out_valid || out_ready.
- Arbitration runs only when slot_free && !rst:
  - Only req_a high: grant A.
  - Only req_b high: grant B.
  - Both high: grant the requester that is not last_served.
  - Neither high: no grant.
- sel, combinational:
  - While granting, sel is the granted side.
  - Otherwise sel holds its registered value, so the mux output is stable when idle.
  - Reset value of registered sel is 0.
- On a grant:
  - The matching ack is high that cycle.
  - At the edge: out_data <= the mux output for sel, out_valid <= 1, last_served <= the granted side, and the granted counter increments.
- Latency: a request presented to an empty slot is granted the same cycle and appears on out_data/out_valid one cycle later.
- Throughput: one word per cycle while out_ready=1. A simultaneous drain and capture is legal.
- Drain without a grant: when out_valid && out_ready and there is no grant, out_valid <= 0 and out_data holds its last value.
- Backpressure: when out_valid && !out_ready:
  - No grant is issued; ack_a = ack_b = 0.
  - out_data, out_valid and last_served hold.
  - Pending requests wait.
- Counters: saturate at 2^CNT_W-1 and never wrap. The other counter keeps counting.
- Fairness: with both requesters continuously high and out_ready=1, grants strictly alternate A, B, A, B.
- Reset mid-operation: any held word is discarded and everything returns to reset values on the next edge. A requester holding req across reset is re-arbitrated normally after reset deasserts.
- Single-beat rule: a requester never gets two acks for one word. Requesters deassert req or present new data the cycle after ack.
- Internal state machine:
  - EMPTY (out_valid=0) -> FULL on a grant.
  - FULL -> FULL on drain+grant or on stall.
  - FULL -> EMPTY on drain without a grant.

Decomposition:
- Shared package mux_arb_pkg holds:
  - localparam SEL_A=1'b0, SEL_B=1'b1
  - typedef enum {EMPTY, FULL} slot_state_t
- Sub-module mux2_w, a parameterised WIDTH 2:1 mux (y = s ? b : a), instantiated once for the data path. The arbiter, slot register and counters stay in mux_share_arb.

Test Plan (all with WIDTH=2, CNT_W=8):
- Reset, then idle with rst=1 for 2 cycles, then released: out_valid=0, out_data=0, cnt_a=cnt_b=0, ack_a=ack_b=0, sel=0.
- Single requester: req_a=1, data_a=2'b10, out_ready=1. Required: ack_a=1 that cycle and sel=0; next cycle out_valid=1, out_data=2'b10, cnt_a=1.
- Contention: req_a=req_b=1, data_a=2'b01, data_b=2'b11, out_ready=1 for 4 cycles. Required: grants A, B, A, B; out_data sequence 01, 11, 01, 11; cnt_a=cnt_b=2.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with req_b=1. Required: ack_b=0 and out_data stable; when out_ready rises, B is granted the same cycle and its data appears the next cycle.
- Saturation: CNT_W=8, req_a held for 300 accepted words. Required: cnt_a stops at 255 while cnt_b stays 0.
- Mid-operation reset: rst=1 while out_valid=1. Required: next edge gives out_valid=0 and counters 0; with req_a=req_b=1 after release, A is granted first.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared select encoding and output-slot state type for the shared-mux arbiter.
package mux_arb_pkg;
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic {EMPTY, FULL} slot_state_t;
endpackage

// File: rtl/mux2_w.sv
// Parameterised-width 2:1 mux: s=0 passes a, s=1 passes b.
module mux2_w #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);
    assign y = s ? b : a;
endmodule

// File: rtl/mux_share_arb.sv
// Round-robin arbiter sharing one 2:1 mux between requesters A and B,
// feeding a single-entry valid/ready output register with saturating grant counters.
module mux_share_arb
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             ack_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    output logic             ack_b,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_ONE;
    endfunction

    slot_state_t      state, state_next;
    logic             sel_q;
    logic             last_served;
    logic             slot_free;
    logic             arb_en;
    logic             grant_a, grant_b, grant;
    logic [WIDTH-1:0] mux_y;

    assign slot_free = (state == EMPTY) || out_ready;
    assign arb_en    = slot_free && !rst;

    // On contention, the side that was not served last wins.
    assign grant_a = arb_en && req_a && (!req_b || last_served == SEL_B);
    assign grant_b = arb_en && req_b && (!req_a || last_served == SEL_A);
    assign grant   = grant_a || grant_b;

    assign ack_a = grant_a;
    assign ack_b = grant_b;
    assign sel   = grant_a ? SEL_A : (grant_b ? SEL_B : sel_q);

    mux2_w #(.WIDTH(WIDTH)) u_mux (
        .a (data_a),
        .b (data_b),
        .s (sel),
        .y (mux_y)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (grant) state_next = FULL;
            FULL:    if (out_ready && !grant) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state == FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q       <= SEL_A;
            last_served <= SEL_B;
            out_data    <= '0;
            cnt_a       <= '0;
            cnt_b       <= '0;
        end else begin
            sel_q <= sel;
            if (grant) begin
                out_data    <= mux_y;
                last_served <= grant_b ? SEL_B : SEL_A;
            end
            if (grant_a) cnt_a <= sat_inc(cnt_a);
            if (grant_b) cnt_b <= sat_inc(cnt_b);
        end
    end
endmodule

// File: tb/tb_mux_share_arb.sv
// Directed, table-driven bench for mux_share_arb with a hand-written counter saturation run.
module tb_mux_share_arb;
    localparam int WIDTH = 2;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             req_a, req_b;
    logic [WIDTH-1:0] data_a, data_b;
    logic             ack_a, ack_b, sel;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] cnt_a, cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    mux_share_arb #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .data_a    (data_a),
        .ack_a     (ack_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .ack_b     (ack_b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ra;
        logic [1:0] da;
        logic       rb;
        logic [1:0] db;
        logic       rdy;
        logic       e_ack_a;
        logic       e_ack_b;
        logic       e_sel;
        logic       e_ov;
        logic [1:0] e_od;
        int         e_ca;
        int         e_cb;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic ra, input logic [1:0] da,
                                input logic rb, input logic [1:0] db, input logic rdy,
                                input logic eaa, input logic eab, input logic es,
                                input logic eov, input logic [1:0] eod, input int eca, input int ecb);
        vec_t v;
        v.rst = r; v.ra = ra; v.da = da; v.rb = rb; v.db = db; v.rdy = rdy;
        v.e_ack_a = eaa; v.e_ack_b = eab; v.e_sel = es;
        v.e_ov = eov; v.e_od = eod; v.e_ca = eca; v.e_cb = ecb;
        return v;
    endfunction

    initial begin
        //            rst ra da     rb db     rdy  ackA ackB sel  ov  od    ca cb
        vecs[0]  = mk(1, 0, 2'b00, 0, 2'b00, 0,   0,   0,   0,   0, 2'b00, 0, 0);
        vecs[1]  = mk(1, 0, 2'b00, 0, 2'b00, 0,   0,   0,   0,   0, 2'b00, 0, 0);
        vecs[2]  = mk(0, 0, 2'b00, 0, 2'b00, 0,   0,   0,   0,   0, 2'b00, 0, 0);
        vecs[3]  = mk(0, 1, 2'b10, 0, 2'b00, 1,   1,   0,   0,   1, 2'b10, 1, 0);
        vecs[4]  = mk(0, 0, 2'b00, 0, 2'b00, 1,   0,   0,   0,   0, 2'b10, 1, 0);
        vecs[5]  = mk(1, 0, 2'b00, 0, 2'b00, 1,   0,   0,   0,   0, 2'b00, 0, 0);
        vecs[6]  = mk(0, 1, 2'b01, 1, 2'b11, 1,   1,   0,   0,   1, 2'b01, 1, 0);
        vecs[7]  = mk(0, 1, 2'b01, 1, 2'b11, 1,   0,   1,   1,   1, 2'b11, 1, 1);
        vecs[8]  = mk(0, 1, 2'b01, 1, 2'b11, 1,   1,   0,   0,   1, 2'b01, 2, 1);
        vecs[9]  = mk(0, 1, 2'b01, 1, 2'b11, 1,   0,   1,   1,   1, 2'b11, 2, 2);
        vecs[10] = mk(0, 0, 2'b00, 1, 2'b10, 0,   0,   0,   1,   1, 2'b11, 2, 2);
        vecs[11] = mk(0, 0, 2'b00, 1, 2'b10, 0,   0,   0,   1,   1, 2'b11, 2, 2);
        vecs[12] = mk(0, 0, 2'b00, 1, 2'b10, 0,   0,   0,   1,   1, 2'b11, 2, 2);
        vecs[13] = mk(0, 0, 2'b00, 1, 2'b10, 1,   0,   1,   1,   1, 2'b10, 2, 3);
        vecs[14] = mk(0, 0, 2'b00, 0, 2'b00, 0,   0,   0,   1,   1, 2'b10, 2, 3);
        vecs[15] = mk(1, 1, 2'b01, 1, 2'b10, 0,   0,   0,   1,   0, 2'b00, 0, 0);
        vecs[16] = mk(0, 1, 2'b01, 1, 2'b10, 1,   1,   0,   0,   1, 2'b01, 1, 0);
        vecs[17] = mk(0, 1, 2'b01, 1, 2'b10, 1,   0,   1,   1,   1, 2'b10, 1, 1);

        rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
        data_a = '0; data_b = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 18; i++) begin
            rst = vecs[i].rst; req_a = vecs[i].ra; data_a = vecs[i].da;
            req_b = vecs[i].rb; data_b = vecs[i].db; out_ready = vecs[i].rdy;
            #2;
            check("ack_a", i, ack_a, vecs[i].e_ack_a);
            check("ack_b", i, ack_b, vecs[i].e_ack_b);
            check("sel",   i, sel,   vecs[i].e_sel);
            @(posedge clk);
            #1;
            check("out_valid", i, out_valid, vecs[i].e_ov);
            check("out_data",  i, out_data,  vecs[i].e_od);
            check("cnt_a",     i, cnt_a,     vecs[i].e_ca);
            check("cnt_b",     i, cnt_b,     vecs[i].e_cb);
        end

        // Saturation: 300 back-to-back A words, new data every beat.
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            req_a = 1'b1;
            data_a = k[1:0];
            #2;
            check("sat_ack_a", k, ack_a, 1'b1);
            @(posedge clk);
            #1;
            check("sat_out_data", k, out_data, k[1:0]);
            if (k == 254 || k == 255 || k == 256)
                check("sat_cnt_a_edge", k, cnt_a, (k > 255) ? 255 : k);
        end
        req_a = 1'b0;
        check("sat_cnt_a", 300, cnt_a, 255);
        check("sat_cnt_b", 300, cnt_b, 0);
        check("sat_out_valid", 300, out_valid, 1'b1);
        @(posedge clk);
        #1;
        check("sat_drain_valid", 301, out_valid, 1'b0);
        check("sat_cnt_a_hold", 301, cnt_a, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
